imm_encoder: RTL and testbench

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder.sv | 136 +++++++++++++
 tb/tb_imm_encoder.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
`default_nettype none
// imm_encoder: packs an immediate into a RISC-V instruction word through a one-deep
// valid/ready output register. Define IMM_ENCODER_RANGECHK_EN to flag out-of-range immediates.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ImmSrc,
  input  logic [31:0]      imm,
  input  logic [31:0]      base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0]       FMT_I   = 3'b001;
  localparam logic [2:0]       FMT_S   = 3'b010;
  localparam logic [2:0]       FMT_B   = 3'b011;
  localparam logic [2:0]       FMT_U   = 3'b100;
  localparam logic [2:0]       FMT_J   = 3'b101;
  localparam logic [2:0]       FMT_SH  = 3'b110;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]      enc_instr;
  logic             fmt_invalid;
  logic             range_bad;
  logic             enc_err;
  logic             accept;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      instr_q, instr_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] enc_count_q, enc_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  always_comb begin
    enc_instr   = base;
    fmt_invalid = 1'b0;
    case (ImmSrc)
      FMT_I: enc_instr[31:20] = imm[11:0];
      FMT_S: begin
        enc_instr[31:25] = imm[11:5];
        enc_instr[11:7]  = imm[4:0];
      end
      FMT_B: begin
        enc_instr[31]    = imm[12];
        enc_instr[7]     = imm[11];
        enc_instr[30:25] = imm[10:5];
        enc_instr[11:8]  = imm[4:1];
      end
      FMT_U: enc_instr[31:12] = imm[31:12];
      FMT_J: begin
        enc_instr[31]    = imm[20];
        enc_instr[30:21] = imm[10:1];
        enc_instr[20]    = imm[11];
        enc_instr[19:12] = imm[19:12];
      end
      // funct7 in base[31:25] stays intact; only shamt comes from imm
      FMT_SH: enc_instr[24:20] = imm[4:0];
      default: fmt_invalid = 1'b1;
    endcase
  end

`ifdef IMM_ENCODER_RANGECHK_EN
  // Representable when every bit above the field's sign bit copies it
  always_comb begin
    range_bad = 1'b0;
    case (ImmSrc)
      FMT_I, FMT_S: range_bad = (imm[31:11] != {21{imm[11]}});
      FMT_B:        range_bad = (imm[31:12] != {20{imm[12]}}) || imm[0];
      FMT_U:        range_bad = (imm[11:0] != 12'h000);
      FMT_J:        range_bad = (imm[31:20] != {12{imm[20]}}) || imm[0];
      FMT_SH:       range_bad = (imm[31:5] != 27'h0);
      default:      range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  assign enc_err  = fmt_invalid | range_bad;
  assign in_ready = !reset && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    err_d       = err_q;
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (accept) begin
      out_valid_d = 1'b1;
      instr_d     = enc_instr;
      err_d       = enc_err;
      if (enc_count_q != CNT_MAX) begin
        enc_count_d = enc_count_q + CNT_ONE;
      end
      if (enc_err && (err_count_q != CNT_MAX)) begin
        err_count_d = err_count_q + CNT_ONE;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      instr_q     <= 32'h0;
      err_q       <= 1'b0;
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign instr     = instr_q;
  assign err       = err_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// tb_imm_encoder: randomized and directed checks of imm_encoder against a bit-map reference model.
module tb_imm_encoder;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef IMM_ENCODER_RANGECHK_EN
  localparam bit RCHK = 1'b1;
`else
  localparam bit RCHK = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } word_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ImmSrc;
  logic [31:0]      imm;
  logic [31:0]      base;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      instr;
  logic             err;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  int checks   = 0;
  int failures = 0;

  word_t            exp_q[$];
  logic [CNT_W-1:0] m_enc = '0;
  logic [CNT_W-1:0] m_err = '0;

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .ImmSrc(ImmSrc), .imm(imm), .base(base),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .err(err),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Which imm bit lands in instruction bit k (-1: bit comes from base)
  function automatic int src_bit(input logic [2:0] f, input int k);
    case (f)
      3'b001: return (k >= 20) ? k - 20 : -1;
      3'b010: begin
        if (k >= 25) return k - 20;
        if (k >= 7 && k <= 11) return k - 7;
        return -1;
      end
      3'b011: begin
        if (k == 31) return 12;
        if (k == 7) return 11;
        if (k >= 25 && k <= 30) return k - 20;
        if (k >= 8 && k <= 11) return k - 7;
        return -1;
      end
      3'b100: return (k >= 12) ? k : -1;
      3'b101: begin
        if (k == 31) return 20;
        if (k >= 21 && k <= 30) return k - 20;
        if (k == 20) return 11;
        if (k >= 12 && k <= 19) return k;
        return -1;
      end
      3'b110: return (k >= 20 && k <= 24) ? k - 20 : -1;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] ref_instr(input logic [2:0] f, input logic [31:0] im,
                                            input logic [31:0] b);
    logic [31:0] r;
    r = b;
    for (int k = 0; k < 32; k++) begin
      int s;
      s = src_bit(f, k);
      if (s >= 0) r[k] = im[s];
    end
    return r;
  endfunction

  function automatic logic ref_err(input logic [2:0] f, input logic [31:0] im);
    longint s;
    logic   bad;
    s = longint'($signed(im));
    case (f)
      3'b001, 3'b010: bad = (s < -2048) || (s > 2047);
      3'b011:         bad = (s < -4096) || (s > 4095) || (im % 32'd2 != 0);
      3'b100:         bad = (im % 32'd4096) != 0;
      3'b101:         bad = (s < -1048576) || (s > 1048575) || (im % 32'd2 != 0);
      3'b110:         bad = im > 32'd31;
      default:        return 1'b1;
    endcase
    return RCHK && bad;
  endfunction

  function automatic logic [31:0] pick_imm();
    logic [31:0] bnd [13];
    logic [31:0] t;
    bnd = '{32'h7FF, 32'hFFFFF800, 32'h800, 32'hFFFFF7FF, 32'hFFE, 32'hFFFFF000, 32'h1000,
            32'hFFFFEFFE, 32'hFFFFE, 32'hFFF00000, 32'h100000, 32'h1F, 32'h20};
    case ($urandom_range(0, 5))
      0: t = $urandom;
      1: t = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: t = bnd[$urandom_range(0, 12)];
      3: t = 32'($urandom_range(0, 63));
      4: begin t = $urandom; t[11:0] = 12'h000; end
      default: t = 32'($urandom_range(0, 4194304)) - 32'd2097152;
    endcase
    return t;
  endfunction

  function automatic logic model_valid();
    return exp_q.size() != 0;
  endfunction

  function automatic logic model_ready();
    return !reset && (!model_valid() || out_ready);
  endfunction

  task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] im,
                       input logic [31:0] b, input logic ordy);
    in_valid  = v;
    ImmSrc    = f;
    imm       = im;
    base      = b;
    out_ready = ordy;
  endtask

  // Advance the reference model across the coming rising edge, then step past it
  task automatic tick();
    logic  ov;
    logic  acc;
    word_t w;
    ov  = model_valid();
    acc = in_valid && model_ready();
    if (reset) begin
      exp_q.delete();
      m_enc = '0;
      m_err = '0;
    end else begin
      if (ov && out_ready) void'(exp_q.pop_front());
      if (acc) begin
        w.instr = ref_instr(ImmSrc, imm, base);
        w.err   = ref_err(ImmSrc, imm);
        exp_q.push_back(w);
        if (m_enc != CNT_MAX) m_enc = m_enc + 1'b1;
        if (w.err && m_err != CNT_MAX) m_err = m_err + 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 3'b001, 32'h5, 32'h13, 1'b1);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({out_valid, err, instr, enc_count, err_count} !== '0) begin
      failures++;
      $display("FAIL reset_state got ov=%b err=%b instr=%h enc=%0d errc=%0d exp all zero",
               out_valid, err, instr, enc_count, err_count);
    end
    tick();
    reset = 1'b0;
    drive(1'b1, 3'b001, 32'h5, 32'h13, 1'b1);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL first_accept_ready got=%b exp=1", in_ready);
    end
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || instr !== 32'h00500013 || enc_count !== 4'd1) begin
      failures++;
      $display("FAIL first_word got ov=%b instr=%h enc=%0d exp ov=1 instr=00500013 enc=1",
               out_valid, instr, enc_count);
    end
    tick();
  endtask

  task automatic test_vectors();
    drive(1'b1, 3'b001, 32'hFFFFF800, 32'h00000013, 1'b1);
    @(negedge clk); tick();
    drive(1'b1, 3'b011, 32'h00000FFE, 32'h00000063, 1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || instr !== 32'h80000013 || err !== 1'b0) begin
      failures++; $display("FAIL vec_I got ov=%b instr=%h err=%b exp ov=1 instr=80000013 err=0",
                           out_valid, instr, err);
    end
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || instr !== 32'h7E000FE3 || err !== 1'b0) begin
      failures++; $display("FAIL vec_B got ov=%b instr=%h err=%b exp ov=1 instr=7E000FE3 err=0",
                           out_valid, instr, err);
    end
    tick();
    reset = 1'b1;
    @(negedge clk); tick();
    reset = 1'b0;
    drive(1'b1, 3'b101, 32'h00000801, 32'h0000006F, 1'b1);
    @(negedge clk); tick();
    drive(1'b1, 3'b111, 32'h12345678, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    checks++;
    if (instr !== 32'h0010006F || err !== RCHK || err_count !== CNT_W'(RCHK)) begin
      failures++; $display("FAIL vec_J got instr=%h err=%b errc=%0d exp instr=0010006F err=%b errc=%0d",
                           instr, err, err_count, RCHK, RCHK);
    end
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (instr !== 32'hDEADBEEF || err !== 1'b1) begin
      failures++; $display("FAIL vec_invalid got instr=%h err=%b exp instr=DEADBEEF err=1",
                           instr, err);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f  [3];
    logic [31:0] im [3];
    logic [31:0] b  [3];
    int idx;
    for (int i = 0; i < 3; i++) begin
      f[i]  = 3'($urandom_range(1, 6));
      im[i] = pick_imm();
      b[i]  = $urandom;
    end
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, f[idx], im[idx], b[idx], 1'b0);
      @(negedge clk);
      checks++;
      if (in_ready !== (c == 0)) begin
        failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", c, in_ready, c == 0);
      end
      if (c > 0) begin
        checks++;
        if (out_valid !== 1'b1 || instr !== ref_instr(f[0], im[0], b[0])) begin
          failures++; $display("FAIL bp_hold cyc=%0d got ov=%b instr=%h exp ov=1 instr=%h",
                               c, out_valid, instr, ref_instr(f[0], im[0], b[0]));
        end
      end
      if (in_ready) idx++;
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      if (idx < 3) drive(1'b1, f[idx], im[idx], b[idx], 1'b1);
      else         drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      checks++;
      if (c < 3) begin
        if (out_valid !== 1'b1 || instr !== ref_instr(f[c], im[c], b[c]) ||
            err !== ref_err(f[c], im[c]) || in_ready !== 1'b1) begin
          failures++; $display("FAIL bp_drain idx=%0d got ov=%b rdy=%b instr=%h err=%b exp instr=%h err=%b",
                               c, out_valid, in_ready, instr, err,
                               ref_instr(f[c], im[c], b[c]), ref_err(f[c], im[c]));
        end
      end else if (out_valid !== 1'b0) begin
        failures++; $display("FAIL bp_empty got ov=%b exp=0", out_valid);
      end
      if (idx < 3 && in_ready) idx++;
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 3'b001, 32'h1, 32'h13, 1'b0);
    @(negedge clk); tick();
    reset = 1'b1;
    drive(1'b1, 3'b001, 32'h2, 32'h13, 1'b0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL mid_reset_pre got rdy=%b ov=%b exp rdy=0 ov=1", in_ready, out_valid);
    end
    tick();
    reset = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || enc_count !== '0 || err_count !== '0) begin
      failures++; $display("FAIL mid_reset_post got ov=%b enc=%0d errc=%0d exp 0 0 0",
                           out_valid, enc_count, err_count);
    end
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 3'b111, $urandom, $urandom, 1'b1);
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (instr !== exp_q[0].instr || err !== 1'b1) begin
          failures++; $display("FAIL sat_word i=%0d got instr=%h err=%b exp instr=%h err=1",
                               i, instr, err, exp_q[0].instr);
        end
      end
      tick();
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (enc_count !== 4'd15 || err_count !== 4'd15) begin
      failures++; $display("FAIL saturation got enc=%0d errc=%0d exp 15 15", enc_count, err_count);
    end
    tick();
  endtask

  task automatic test_random();
    reset = 1'b1;
    @(negedge clk); tick();
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), pick_imm(), $urandom,
            ($urandom_range(0, 2) != 0));
      @(negedge clk);
      checks++;
      if (out_valid !== model_valid() || in_ready !== model_ready()) begin
        failures++; $display("FAIL rand_hs cyc=%0d got ov=%b rdy=%b exp ov=%b rdy=%b",
                             c, out_valid, in_ready, model_valid(), model_ready());
      end
      if (model_valid()) begin
        checks++;
        if (instr !== exp_q[0].instr || err !== exp_q[0].err) begin
          failures++; $display("FAIL rand_word cyc=%0d got instr=%h err=%b exp instr=%h err=%b",
                               c, instr, err, exp_q[0].instr, exp_q[0].err);
        end
      end
      checks++;
      if (enc_count !== m_enc || err_count !== m_err) begin
        failures++; $display("FAIL rand_counts cyc=%0d got enc=%0d errc=%0d exp enc=%0d errc=%0d",
                             c, enc_count, err_count, m_enc, m_err);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_midstream();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
